accum_seg_scan: RTL and testbench

ACCUM_SEG_SCAN -- requirements
Module: accum_seg_scan

---
 rtl/accum_seg_scan_pkg.sv | 15 +
 rtl/hex7seg_dec.sv | 11 +
 rtl/accum_seg_scan.sv | 117 +++++++++++
 tb/tb_accum_seg_scan.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/accum_seg_scan_pkg.sv
// rtl/accum_seg_scan_pkg.sv - shared mode encodings and seven-segment table
package accum_seg_scan_pkg;

  localparam logic [1:0] MODE_ADD     = 2'b00;
  localparam logic [1:0] MODE_SUB     = 2'b01;
  localparam logic [1:0] MODE_ACC_ADD = 2'b10;
  localparam logic [1:0] MODE_ACC_SUB = 2'b11;

  // Active-high segments, bit 0 = a .. bit 6 = g.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7seg_dec.sv
// rtl/hex7seg_dec.sv - combinational hex nibble to seven-segment decode
module hex7seg_dec
  import accum_seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/accum_seg_scan.sv
// rtl/accum_seg_scan.sv - add/sub accumulator with multiplexed hex display scan
module accum_seg_scan
  import accum_seg_scan_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SCAN_DIV = 1000
) (
  input  logic                   c,
  input  logic                   r,
  input  logic [WIDTH-1:0]       f,
  input  logic [WIDTH-1:0]       g,
  input  logic                   l,
  input  logic [1:0]             m,
  output logic [WIDTH-1:0]       acc,
  output logic                   v,
  output logic [WIDTH/4-1:0]     an,
  output logic [6:0]             q
);

  localparam int DIGITS = WIDTH / 4;
  localparam int PS_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int D_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);
  localparam logic [D_W-1:0]  D_LAST  = D_W'(DIGITS - 1);

  logic [WIDTH-1:0]  op_x;
  logic [WIDTH-1:0]  op_y;
  logic              sub;
  logic [WIDTH:0]    sum;
  logic              v_next;

  logic [PS_W-1:0]   ps;
  logic [D_W-1:0]    d;
  logic [D_W-1:0]    d_next;
  logic              tick;
  logic [DIGITS-1:0] an_next;
  logic [3:0]        nibble;

  always_comb begin
    op_x = f;
    op_y = g;
    sub  = 1'b0;
    case (m)
      MODE_ADD: begin
        op_x = f;
        op_y = g;
      end
      MODE_SUB: begin
        sub = 1'b1;
      end
      MODE_ACC_ADD: begin
        op_x = acc;
        op_y = f;
      end
      MODE_ACC_SUB: begin
        op_x = acc;
        op_y = f;
        sub  = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtract as X + ~Y + 1; the carry out is then the inverse of the borrow.
  assign sum    = {1'b0, op_x} + {1'b0, (sub ? ~op_y : op_y)} + {{WIDTH{1'b0}}, sub};
  assign v_next = sub ? ~sum[WIDTH] : sum[WIDTH];

  assign tick = (ps == PS_LAST);

  always_comb begin
    d_next = d;
    if (tick) begin
      d_next = (d == D_LAST) ? '0 : d + 1'b1;
    end
  end

  always_comb begin
    an_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      an_next[i] = (d_next == D_W'(i));
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      acc <= '0;
      v   <= 1'b0;
      ps  <= '0;
      d   <= '0;
      an  <= DIGITS'(1);
    end else begin
      if (l) begin
        acc <= sum[WIDTH-1:0];
        v   <= v_next;
      end
      ps <= tick ? '0 : ps + 1'b1;
      d  <= d_next;
      an <= an_next;
    end
  end

  // Digit multiplexer in front of the single decoder.
  always_comb begin
    nibble = acc[3:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (d == D_W'(i)) begin
        nibble = acc[4*i +: 4];
      end
    end
  end

  hex7seg_dec u_dec (
    .nibble (nibble),
    .seg    (q)
  );

endmodule

// File: tb/tb_accum_seg_scan.sv
// tb/tb_accum_seg_scan.sv - scoreboard bench for accum_seg_scan (WIDTH=16, SCAN_DIV=4)
module tb_accum_seg_scan;

  logic        c;
  logic        r;
  logic [15:0] f;
  logic [15:0] g;
  logic        l;
  logic [1:0]  m;
  logic [15:0] acc;
  logic        v;
  logic [3:0]  an;
  logic [6:0]  q;

  int vectors     = 0;
  int miscompares = 0;

  logic [27:0] sb [$];

  logic [6:0] seg_ref [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int unsigned m_acc = 0;
  logic        m_v   = 1'b0;
  int unsigned m_t   = 0;

  accum_seg_scan #(.WIDTH(16), .SCAN_DIV(4)) dut (
    .c   (c),
    .r   (r),
    .f   (f),
    .g   (g),
    .l   (l),
    .m   (m),
    .acc (acc),
    .v   (v),
    .an  (an),
    .q   (q)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  // State after one rising edge, from arithmetic on whole numbers.
  task automatic model_edge(input logic rr, input logic ll, input logic [1:0] mm,
                            input logic [15:0] ff, input logic [15:0] gg);
    int unsigned x, y, digit;
    logic [3:0]  e_an;
    logic [6:0]  e_q;
    if (rr) begin
      m_acc = 0;
      m_v   = 1'b0;
      m_t   = 0;
    end else begin
      if (ll) begin
        case (mm)
          2'b00: begin x = ff;    y = gg; end
          2'b01: begin x = ff;    y = gg; end
          2'b10: begin x = m_acc; y = ff; end
          default: begin x = m_acc; y = ff; end
        endcase
        if (mm == 2'b01 || mm == 2'b11) begin
          m_v   = (x < y);
          m_acc = (x + 65536 - y) % 65536;
        end else begin
          m_v   = ((x + y) > 65535);
          m_acc = (x + y) % 65536;
        end
      end
      m_t = m_t + 1;
    end
    digit = (m_t / 4) % 4;
    e_an  = 4'(1 << digit);
    e_q   = seg_ref[(m_acc >> (4 * digit)) % 16];
    sb.push_back({16'(m_acc), m_v, e_an, e_q});
  endtask

  task automatic step(input logic rr, input logic ll, input logic [1:0] mm,
                      input logic [15:0] ff, input logic [15:0] gg);
    @(negedge c);
    r = rr;
    l = ll;
    m = mm;
    f = ff;
    g = gg;
    model_edge(rr, ll, mm, ff, gg);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 2'($urandom), 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic chk_av(input string name, input logic [15:0] ea, input logic ev);
    @(posedge c);
    #3;
    vectors++;
    if (acc !== ea || v !== ev) begin
      miscompares++;
      $display("FAIL %s: got acc=%h v=%b, want acc=%h v=%b", name, acc, v, ea, ev);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] ea, input logic ev,
                         input logic [3:0] ean, input logic [6:0] eq);
    @(posedge c);
    #3;
    vectors++;
    if (acc !== ea || v !== ev || an !== ean || q !== eq) begin
      miscompares++;
      $display("FAIL %s: got acc=%h v=%b an=%b q=%h, want acc=%h v=%b an=%b q=%h",
               name, acc, v, an, q, ea, ev, ean, eq);
    end
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: every cycle the DUT presents a new state; compare against the queue head.
  initial begin
    logic [27:0] e;
    forever begin
      @(posedge c);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if ({acc, v, an, q} !== e) begin
          miscompares++;
          $display("FAIL sb: got acc=%h v=%b an=%b q=%h, want acc=%h v=%b an=%b q=%h",
                   acc, v, an, q, e[27:12], e[11], e[10:7], e[6:0]);
        end
      end
    end
  end

  initial begin
    logic [15:0] a, b;
    r = 1'b1;
    l = 1'b0;
    m = 2'b00;
    f = '0;
    g = '0;

    step(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000);
    chk_all("reset", 16'h0000, 1'b0, 4'b0001, 7'h3F);

    step(1'b0, 1'b1, 2'b00, 16'h1234, 16'h0FFF);
    chk_av("add", 16'h2233, 1'b0);
    step(1'b0, 1'b1, 2'b00, 16'hFFFF, 16'h0001);
    chk_av("add_carry", 16'h0000, 1'b1);

    step(1'b0, 1'b1, 2'b01, 16'h0003, 16'h0005);
    chk_av("sub_borrow", 16'hFFFE, 1'b1);
    step(1'b0, 1'b1, 2'b01, 16'h0005, 16'h0003);
    chk_av("sub", 16'h0002, 1'b0);

    step(1'b0, 1'b1, 2'b00, 16'h0010, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b10, 16'h0001, 16'($urandom));
    chk_av("acc_add", 16'h0013, 1'b0);
    idle(5);
    chk_av("hold", 16'h0013, 1'b0);

    step(1'b0, 1'b1, 2'b11, 16'h0014, 16'h0000);
    chk_av("acc_sub_borrow", 16'hFFFF, 1'b1);

    // Scan pattern with A5C3 loaded just after reset.
    step(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000);
    step(1'b0, 1'b1, 2'b00, 16'hA5C3, 16'h0000);
    idle(19);

    // Reset beats load while digit 2 is shown.
    step(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000);
    step(1'b0, 1'b1, 2'b00, 16'h7654, 16'h0000);
    idle(7);
    step(1'b1, 1'b1, 2'b00, 16'h1111, 16'h2222);
    chk_all("reset_over_load", 16'h0000, 1'b0, 4'b0001, 7'h3F);
    idle(5);

    for (int i = 0; i < 400; i++) begin
      a = pick_operand();
      b = ($urandom_range(0, 7) == 0) ? a : pick_operand();
      step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 2'($urandom), a, b);
    end
    idle(2);

    @(posedge c);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
